// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: time-multiplexed common-anode 7-segment driver with hex decode, dp, blanking and leading-zero suppression
module sevenseg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 2,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_en_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [IW-1:0]           digit_idx_o
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_sh, blank_sh, sup;
  logic [3:0]            cur;
  logic                  run, dead, dark, show_dp;
  assign digit_idx_o = idx;
  // a digit is suppressed when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    run = lz_en_i;
    sup = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run = run & (nib[k] == 4'h0);
      sup[k] = run;
    end
  end
  assign cur     = nib[idx];
  assign dead    = cnt < CW'(DEAD_CYC);
  assign show_dp = dp_sh[idx];
  assign dark    = blank_sh[idx] | sup[idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) nib[k] <= '0;
      an_o     <= '1;
      seg_o    <= 7'h7F;
      dp_o     <= 1'b1;
    end else begin
      if (load_i) begin
        for (int k = 0; k < NUM_DIGITS; k++) nib[k] <= digits_i[4*k +: 4];
        dp_sh    <= dp_i;
        blank_sh <= blank_i;
      end
      cnt <= (cnt == CW'(SCAN_DIV - 1)) ? '0 : cnt + 1'b1;
      if (cnt == CW'(SCAN_DIV - 1)) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      an_o  <= (dead || (dark && !show_dp)) ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg_o <= (dead || dark) ? 7'h7F : ~HEX[cur];
      dp_o  <= dead || !show_dp;
    end
  end
endmodule
